// File: rtl/des_pkg.sv
// +----------------------------------------------------------------------+
// | des_pkg : shared DES permutation tables, shift schedule and helpers  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package des_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ks_state_e;

  // Entries are DES bit numbers (1 = MSB of the source vector).
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = key[64-PC1_TAB[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2_TAB[i]];
    end
    return r;
  endfunction

  // Doubling the word lets a plain shift produce the wrap-around bits.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [55:0] t;
    t = {x, x} >> n;
    return t[27:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_pc2.sv
// +----------------------------------------------------------------------+
// | des_pc2 : combinational PC-2 compression, 56-bit CD to 48-bit subkey |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  assign subkey_o = pc2(cd_i);

endmodule

`default_nettype wire

// File: rtl/des_key_schedule.sv
// +----------------------------------------------------------------------+
// | des_key_schedule : sequential DES round-subkey generator, one subkey |
// | per valid/ready handshake, encrypt or decrypt order                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module des_key_schedule
  import des_pkg::*;
#(
  parameter int NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        e,
  input  logic [63:0] key,
  output logic        idle,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        done
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  ks_state_e   state_q;
  logic        mode_q;
  logic [55:0] cd_q;
  logic [3:0]  round_q;
  logic        done_q;

  logic [55:0] pc1_key;
  logic [55:0] cd_load;
  logic [55:0] cd_next;
  logic [1:0]  enc_shift;
  logic [1:0]  dec_shift;

  always_comb begin
    pc1_key   = pc1(key);
    enc_shift = SHIFT[round_q + 4'd1];
    dec_shift = SHIFT[4'd15 - round_q];
    // Encrypt starts at C1D1; decrypt starts at C16D16, which equals C0D0.
    cd_load   = e ? {rotl28(pc1_key[55:28], SHIFT[0]), rotl28(pc1_key[27:0], SHIFT[0])}
                  : pc1_key;
    cd_next   = mode_q ? {rotl28(cd_q[55:28], enc_shift), rotl28(cd_q[27:0], enc_shift)}
                       : {rotr28(cd_q[55:28], dec_shift), rotr28(cd_q[27:0], dec_shift)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cd_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q  <= e;
            cd_q    <= cd_load;
            round_q <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (sk_ready) begin
            if (round_q == LAST_ROUND) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              round_q <= round_q + 4'd1;
              cd_q    <= cd_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (subkey)
  );

  assign idle     = (state_q == IDLE);
  assign sk_valid = (state_q == ISSUE);
  assign round    = round_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule.sv
// +----------------------------------------------------------------------+
// | tb_des_key_schedule : directed bench with a textbook key-schedule    |
// | model and a per-cycle scoreboard                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_des_key_schedule;

  localparam int NR = 16;
  localparam logic [63:0] KAT  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PKEY = 64'h123456789ABCDEF0;
  localparam logic [63:0] PFLP = 64'h133557799BBDDFF1;

  localparam int PC1T [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2T [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic        clk = 1'b0;
  logic        rst, start, e, sk_ready;
  logic [63:0] key;
  logic        idle, sk_valid, done;
  logic [47:0] subkey;
  logic [3:0]  round;

  always #5 clk = ~clk;

  des_key_schedule #(.NROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .e(e), .key(key),
    .idle(idle), .sk_valid(sk_valid), .sk_ready(sk_ready),
    .subkey(subkey), .round(round), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Kn straight from the textbook: PC1, cumulative left rotation, PC2.
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int n);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] r;
    int rot;
    for (int j = 0; j < 56; j++) cd[55-j] = k[64-PC1T[j]];
    c = cd[55:28];
    d = cd[27:0];
    rot = 0;
    for (int j = 0; j < n; j++) rot += SH[j];
    for (int j = 0; j < rot; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2T[j]];
    return r;
  endfunction

  typedef struct {
    logic [3:0]  rnd;
    logic [47:0] k;
    bit          last;
  } exp_t;

  exp_t        expq[$];
  bit          done_exp = 1'b0;
  bit          armed = 1'b0;
  logic [47:0] log_k[$];
  int          valid_cycles = 0;

  // Scoreboard update on the edge where the DUT samples its inputs.
  always @(posedge clk) begin
    exp_t ent;
    done_exp = 1'b0;
    if (rst) begin
      expq.delete();
      armed = 1'b1;
    end else if (expq.size() != 0) begin
      if (sk_ready) begin
        ent = expq.pop_front();
        done_exp = ent.last;
      end
    end else if (start) begin
      for (int i = 0; i < NR; i++) begin
        ent.rnd  = 4'(i);
        ent.k    = e ? model_subkey(key, i + 1) : model_subkey(key, 16 - i);
        ent.last = (i == NR - 1);
        expq.push_back(ent);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("idle", idle, (expq.size() == 0));
      chk("sk_valid", sk_valid, (expq.size() != 0));
      chk("done", done, done_exp);
      if (expq.size() != 0) begin
        chk("round", round, expq[0].rnd);
        chk("subkey", subkey, expq[0].k);
      end
      if (sk_valid) valid_cycles++;
      if (sk_valid && sk_ready) log_k.push_back(subkey);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  // mode 0: always ready; 1: stall 5 cycles at round 7 then random; 2: random.
  task automatic run_sched(input logic [63:0] k, input logic ee, input int mode);
    int  stall;
    bit  seen;
    log_k.delete();
    valid_cycles = 0;
    key = k; e = ee; start = 1'b1; sk_ready = (mode == 0);
    tick();
    start = 1'b0;
    stall = 0;
    seen  = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (mode == 1) begin
        if (sk_valid && round == 4'd7 && stall < 5) begin
          sk_ready = 1'b0;
          stall++;
        end else if (stall >= 5) sk_ready = 1'($urandom_range(0, 1));
        else sk_ready = 1'b1;
      end else if (mode == 2) begin
        sk_ready = 1'($urandom_range(0, 1));
      end
      tick();
      if (done) seen = 1'b1;
    end
    chk("sched_done_seen", seen, 1'b1);
    sk_ready = 1'b1;
    tick();
  endtask

  logic [47:0] enc_log[$];
  logic [47:0] par_log[$];

  initial begin
    rst = 1'b1; start = 1'b0; e = 1'b0; sk_ready = 1'b0; key = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_idle", idle, 1'b1);
    chk("rst_valid", sk_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_round", round, 4'd0);
    chk("rst_subkey", subkey, 48'h0);
    tick();

    // Pin the model against published values.
    chk("model_k1", model_subkey(KAT, 1), 48'h1B02EFFC7072);
    chk("model_k2", model_subkey(KAT, 2), 48'h79AED9DBC9E5);
    chk("model_k16", model_subkey(KAT, 16), 48'hCB3D8B0E17F5);

    // Encrypt known answer.
    run_sched(KAT, 1'b1, 0);
    chk("enc_count", log_k.size(), NR);
    chk("enc_valid_cycles", valid_cycles, NR);
    if (log_k.size() == NR) begin
      chk("enc_r0", log_k[0], 48'h1B02EFFC7072);
      chk("enc_r1", log_k[1], 48'h79AED9DBC9E5);
      chk("enc_r15", log_k[15], 48'hCB3D8B0E17F5);
    end
    enc_log = log_k;

    // Decrypt order is the exact reverse.
    run_sched(KAT, 1'b0, 0);
    chk("dec_count", log_k.size(), NR);
    if (log_k.size() == NR && enc_log.size() == NR) begin
      chk("dec_r0", log_k[0], 48'hCB3D8B0E17F5);
      chk("dec_r15", log_k[15], 48'h1B02EFFC7072);
      for (int i = 0; i < NR; i++) chk("dec_reverse", log_k[i], enc_log[NR-1-i]);
    end

    // Backpressure: fixed stall then random, and fully random.
    for (int m = 1; m <= 2; m++) begin
      run_sched(KAT, 1'b1, m);
      chk("bp_count", log_k.size(), NR);
      if (log_k.size() == NR && enc_log.size() == NR)
        for (int i = 0; i < NR; i++) chk("bp_seq", log_k[i], enc_log[i]);
    end

    // Parity bits must not matter.
    run_sched(PKEY, 1'b1, 0);
    par_log = log_k;
    run_sched(PFLP, 1'b1, 0);
    chk("par_count", log_k.size(), NR);
    if (log_k.size() == NR && par_log.size() == NR)
      for (int i = 0; i < NR; i++) chk("parity_equal", log_k[i], par_log[i]);

    // Start while busy is ignored; start in the done cycle is accepted.
    key = KAT; e = 1'b1; start = 1'b1; sk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && !(sk_valid && round == 4'd4); c++) tick();
    key = 64'h0F1E2D3C4B5A6978; e = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_done_seen");
    key = KAT; e = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    key = '0;
    chk("b2b_valid", sk_valid, 1'b1);
    chk("b2b_round", round, 4'd0);
    chk("b2b_subkey", subkey, 48'hCB3D8B0E17F5);
    wait_done("b2b_done_seen");
    tick();

    // Reset mid-schedule.
    key = KAT; e = 1'b1; start = 1'b1; sk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && !(sk_valid && round == 4'd9); c++) tick();
    chk("pre_rst_round", round, 4'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_valid", sk_valid, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("mid_rst_no_done", done, 1'b0);
      tick();
    end
    run_sched(KAT, 1'b1, 0);
    chk("post_rst_count", log_k.size(), NR);
    if (log_k.size() != 0) chk("post_rst_r0", log_k[0], 48'h1B02EFFC7072);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
